// File: rtl/set_assoc_cache.sv
// rtl/set_assoc_cache.sv - write-through, write-allocate set-associative cache with true-LRU replacement
// Optional feature macro: CACHE_STATS_EN adds saturating hit/miss counters (hit_cnt_o, miss_cnt_o).
module set_assoc_cache #(
  parameter int WAYS        = 4,
  parameter int SETS        = 8,
  parameter int BLOCK_BYTES = 16,
  parameter int ADDR_W      = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cpu_valid_i,
  input  logic                     cpu_wen_i,
  input  logic [1:0]               cpu_size_i,
  input  logic [ADDR_W-1:0]        cpu_addr_i,
  input  logic [31:0]              cpu_wdata_i,
  output logic                     cpu_ready_o,
  output logic [31:0]              cpu_rdata_o,
  output logic                     mem_valid_o,
  output logic                     mem_wen_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  output logic [8*BLOCK_BYTES-1:0] mem_wdata_o,
  input  logic                     mem_ready_i,
  input  logic [8*BLOCK_BYTES-1:0] mem_rdata_i
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]              hit_cnt_o,
  output logic [31:0]              miss_cnt_o
`endif
);

  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int LINE_W = 8 * BLOCK_BYTES;

  typedef enum logic [1:0] {COMP_TAG, ALLOCATE, WRITE_THROUGH, RESPOND} state_t;

  state_t state;

  logic [LINE_W-1:0] data_arr  [SETS][WAYS];
  logic [TAG_W-1:0]  tag_arr   [SETS][WAYS];
  logic [WAYS-1:0]   valid_arr [SETS];
  logic [WAY_W-1:0]  age_arr   [SETS][WAYS];

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_set;
  logic [TAG_W-1:0]  req_tag;
  logic [ADDR_W-1:0] line_addr;
  logic [OFF_W-1:0]  size_mask;
  logic [OFF_W-1:0]  off_al;
  int                acc_off;
  int                acc_len;

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic [WAY_W-1:0]  way_q;
  logic [WAY_W-1:0]  lru_way;
  logic [WAY_W-1:0]  age_next [WAYS];

  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] merge_base;
  logic [LINE_W-1:0] merged;
  logic [31:0]       load_word;
  logic              mem_ack;

  assign req_off   = cpu_addr_i[OFF_W-1:0];
  assign req_set   = cpu_addr_i[OFF_W +: IDX_W];
  assign req_tag   = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign line_addr = {cpu_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign off_al    = req_off & ~size_mask;
  assign mem_ack   = mem_valid_o && mem_ready_i;

  // Access size decode: alignment mask and byte count (size 11 behaves as a word)
  always_comb begin
    size_mask = '0;
    acc_len   = 4;
    case (cpu_size_i)
      2'b00:   begin size_mask = '0;         acc_len = 1; end
      2'b01:   begin size_mask = OFF_W'(1);  acc_len = 2; end
      default: begin size_mask = OFF_W'(3);  acc_len = 4; end
    endcase
    acc_off = int'(off_al);
  end

  // Tag lookup; the lowest matching way wins if duplicates ever appear
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_arr[req_set][w] && (tag_arr[req_set][w] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Victim choice: lowest invalid way, otherwise the oldest way
  always_comb begin
    victim = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (age_arr[req_set][w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_arr[req_set][w]) victim = WAY_W'(w);
    end
  end

  // LRU ages after touching lru_way: it becomes youngest, younger ways age by one
  always_comb begin
    lru_way = (state == ALLOCATE) ? way_q : hit_way;
    for (int i = 0; i < WAYS; i++) begin
      if (WAY_W'(i) == lru_way)
        age_next[i] = '0;
      else if (age_arr[req_set][i] < age_arr[req_set][lru_way])
        age_next[i] = age_arr[req_set][i] + 1'b1;
      else
        age_next[i] = age_arr[req_set][i];
    end
  end

  // Store merge into either the freshly filled line or the hit line
  always_comb begin
    merge_base = (state == ALLOCATE) ? mem_rdata_i : data_arr[req_set][hit_way];
    merged     = merge_base;
    for (int b = 0; b < BLOCK_BYTES; b++) begin
      if ((b >= acc_off) && (b < acc_off + acc_len))
        merged[8*b +: 8] = cpu_wdata_i[8*((b - acc_off) & 3) +: 8];
    end
  end

  // Load extraction from the captured line, zero-extended
  always_comb begin
    load_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < acc_len)
        load_word[8*i +: 8] = line_q[8*((acc_off + i) % BLOCK_BYTES) +: 8];
    end
  end

  // Line data and tag storage; written only on a completed memory handshake
  always_ff @(posedge clk) begin
    if (mem_ack && (state == ALLOCATE)) begin
      data_arr[req_set][way_q] <= mem_rdata_i;
      tag_arr[req_set][way_q]  <= req_tag;
    end else if (mem_ack && (state == WRITE_THROUGH)) begin
      data_arr[req_set][way_q] <= line_q;
    end
  end

  // Main controller FSM with registered CPU and memory outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= COMP_TAG;
      cpu_ready_o <= 1'b0;
      cpu_rdata_o <= '0;
      mem_valid_o <= 1'b0;
      mem_wen_o   <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      line_q      <= '0;
      way_q       <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        for (int w = 0; w < WAYS; w++) age_arr[s][w] <= WAY_W'(w);
      end
    end else begin
      case (state)
        COMP_TAG: begin
          cpu_ready_o <= 1'b0;
          // While ready is high the CPU still shows the finished request
          if (cpu_valid_i && !cpu_ready_o) begin
            mem_addr_o <= line_addr;
            if (hit) begin
              way_q <= hit_way;
              for (int i = 0; i < WAYS; i++) age_arr[req_set][i] <= age_next[i];
              if (cpu_wen_i) begin
                line_q      <= merged;
                mem_wdata_o <= merged;
                mem_valid_o <= 1'b1;
                mem_wen_o   <= 1'b1;
                state       <= WRITE_THROUGH;
              end else begin
                line_q <= data_arr[req_set][hit_way];
                state  <= RESPOND;
              end
            end else begin
              way_q       <= victim;
              mem_valid_o <= 1'b1;
              mem_wen_o   <= 1'b0;
              state       <= ALLOCATE;
            end
          end
        end
        ALLOCATE: begin
          if (mem_ready_i) begin
            valid_arr[req_set][way_q] <= 1'b1;
            for (int i = 0; i < WAYS; i++) age_arr[req_set][i] <= age_next[i];
            if (cpu_wen_i) begin
              line_q      <= merged;
              mem_wdata_o <= merged;
              mem_wen_o   <= 1'b1;
              state       <= WRITE_THROUGH;
            end else begin
              line_q      <= mem_rdata_i;
              mem_valid_o <= 1'b0;
              state       <= RESPOND;
            end
          end
        end
        WRITE_THROUGH: begin
          if (mem_ready_i) begin
            mem_valid_o <= 1'b0;
            mem_wen_o   <= 1'b0;
            state       <= RESPOND;
          end
        end
        RESPOND: begin
          cpu_ready_o <= 1'b1;
          cpu_rdata_o <= cpu_wen_i ? 32'h0 : load_word;
          state       <= COMP_TAG;
        end
        default: state <= COMP_TAG;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic accept;
  assign accept = (state == COMP_TAG) && cpu_valid_i && !cpu_ready_o;

  // Saturating counters of accepted hits and misses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else if (accept) begin
      if (hit && (hit_cnt_o != 32'hFFFF_FFFF))   hit_cnt_o  <= hit_cnt_o + 32'd1;
      if (!hit && (miss_cnt_o != 32'hFFFF_FFFF)) miss_cnt_o <= miss_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_set_assoc_cache.sv
// tb/tb_set_assoc_cache.sv - self-checking bench for set_assoc_cache (table vectors + random vs reference model)
module tb_set_assoc_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_valid_i, cpu_wen_i;
  logic [1:0]   cpu_size_i;
  logic [31:0]  cpu_addr_i, cpu_wdata_i;
  logic         cpu_ready_o;
  logic [31:0]  cpu_rdata_o;
  logic         mem_valid_o, mem_wen_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic         mem_ready_i;
  logic [127:0] mem_rdata_i;
`ifdef CACHE_STATS_EN
  logic [31:0]  hit_cnt_o, miss_cnt_o;
`endif

  always #5 clk = ~clk;

  set_assoc_cache dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_valid_i(cpu_valid_i), .cpu_wen_i(cpu_wen_i), .cpu_size_i(cpu_size_i),
    .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_ready_o(cpu_ready_o), .cpu_rdata_o(cpu_rdata_o),
    .mem_valid_o(mem_valid_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i)
`ifdef CACHE_STATS_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  // Backing memory: untouched lines hold byte(a) = a*37+17
  logic [127:0] mem [int unsigned];

  function automatic logic [127:0] get_line(int unsigned idx);
    logic [127:0] l;
    if (mem.exists(idx)) return mem[idx];
    for (int b = 0; b < 16; b++) l[8*b +: 8] = 8'((idx * 16 + b) * 37 + 17);
    return l;
  endfunction

  // Reference cache: per set, the resident tags with their last-use time
  int m_tag [8][4];
  int m_time[8][4];
  int m_cnt [8];
  int stamp, hits, misses;

  function automatic int model_find(int s, int t);
    for (int i = 0; i < m_cnt[s]; i++) if (m_tag[s][i] == t) return i;
    return -1;
  endfunction

  task automatic model_touch(int s, int t);
    int slot;
    slot = model_find(s, t);
    if (slot < 0) begin
      if (m_cnt[s] < 4) begin
        slot = m_cnt[s];
        m_cnt[s]++;
      end else begin
        slot = 0;
        for (int i = 1; i < 4; i++) if (m_time[s][i] < m_time[s][slot]) slot = i;
      end
      m_tag[s][slot] = t;
    end
    stamp++;
    m_time[s][slot] = stamp;
  endtask

  task automatic model_reset();
    for (int s = 0; s < 8; s++) m_cnt[s] = 0;
    hits = 0;
    misses = 0;
  endtask

  // Memory responder state
  int           mem_lat, wait_cnt, rd_cnt, wr_cnt;
  logic [31:0]  exp_addr;
  logic [127:0] exp_wline;

  initial begin
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      if (mem_ready_i) mem_ready_i = 1'b0;
      else if (!mem_valid_o) wait_cnt = 0;
      else if (wait_cnt >= mem_lat) begin
        wait_cnt = 0;
        mem_ready_i = 1'b1;
        chk("mem_addr", mem_addr_o, exp_addr);
        if (mem_wen_o) begin
          wr_cnt++;
          chk("mem_wdata", mem_wdata_o, exp_wline);
          mem[mem_addr_o >> 4] = exp_wline;
        end else begin
          rd_cnt++;
          mem_rdata_i = get_line(mem_addr_o >> 4);
        end
      end else wait_cnt++;
    end
  end

  task automatic do_req(input logic wen, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input int lat, output int reads, output logic [31:0] got);
    int nb, off, idx, s, t, cyc, memcyc;
    bit hit, seen;
    logic [127:0] cur;
    logic [31:0]  exp_rd;
    nb  = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    off = (int'(addr[3:0]) / nb) * nb;
    idx = int'(addr >> 4);
    s   = idx % 8;
    t   = int'(addr >> 7);
    hit = (model_find(s, t) >= 0);
    cur = get_line(idx);
    exp_rd = '0;
    for (int i = 0; i < nb; i++) exp_rd[8*i +: 8] = cur[8*(off+i) +: 8];
    exp_wline = cur;
    if (wen) for (int i = 0; i < nb; i++) exp_wline[8*(off+i) +: 8] = wd[8*i +: 8];
    exp_addr = {addr[31:4], 4'b0000};
    mem_lat = lat;
    rd_cnt = 0;
    wr_cnt = 0;
    cpu_valid_i = 1'b1; cpu_wen_i = wen; cpu_size_i = sz; cpu_addr_i = addr; cpu_wdata_i = wd;
    cyc = 0; memcyc = 0; seen = 0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (mem_valid_o) begin
        memcyc++;
        chk("mem_addr_hold", mem_addr_o, exp_addr);
      end
      if (cpu_ready_o) seen = 1;
    end
    chk("ready_seen", seen, 1);
    chk("latency", cyc, 2 + memcyc);
    chk("mem_reads", rd_cnt, hit ? 0 : 1);
    chk("mem_writes", wr_cnt, wen ? 1 : 0);
    if (!wen) chk("load_data", cpu_rdata_o, exp_rd);
    got = cpu_rdata_o;
    reads = rd_cnt;
    cpu_valid_i = 1'b0;
    @(negedge clk);
    chk("ready_pulse", cpu_ready_o, 0);
    model_touch(s, t);
    if (hit) hits++; else misses++;
  endtask

  typedef struct {
    logic        wen;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    int          lat;
    bit          exp_hit;
    bit          chk_data;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vt[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int reads;
    logic [31:0] got;
    logic w;
    logic [1:0] z;
    logic [31:0] a;

    vt.push_back('{1'b0, 2'd0, 32'h100, 32'h0,        2,  1'b0, 1'b1, 32'h11});
    vt.push_back('{1'b0, 2'd0, 32'h100, 32'h0,        0,  1'b1, 1'b1, 32'h11});
    vt.push_back('{1'b0, 2'd1, 32'h101, 32'h0,        0,  1'b1, 1'b1, 32'h3611});
    vt.push_back('{1'b1, 2'd2, 32'h104, 32'hDEADBEEF, 1,  1'b1, 1'b0, 32'h0});
    vt.push_back('{1'b0, 2'd2, 32'h104, 32'h0,        0,  1'b1, 1'b1, 32'hDEADBEEF});
    vt.push_back('{1'b0, 2'd3, 32'h107, 32'h0,        0,  1'b1, 1'b1, 32'hDEADBEEF});
    vt.push_back('{1'b0, 2'd2, 32'h180, 32'h0,        0,  1'b0, 1'b1, 32'h00DBB691});
    vt.push_back('{1'b0, 2'd2, 32'h200, 32'h0,        1,  1'b0, 1'b0, 32'h0});
    vt.push_back('{1'b0, 2'd2, 32'h280, 32'h0,        10, 1'b0, 1'b0, 32'h0});
    vt.push_back('{1'b0, 2'd0, 32'h10F, 32'h0,        0,  1'b1, 1'b0, 32'h0});
    vt.push_back('{1'b0, 2'd2, 32'h300, 32'h0,        0,  1'b0, 1'b0, 32'h0});
    vt.push_back('{1'b0, 2'd2, 32'h100, 32'h0,        0,  1'b1, 1'b0, 32'h0});
    vt.push_back('{1'b0, 2'd2, 32'h200, 32'h0,        0,  1'b1, 1'b0, 32'h0});
    vt.push_back('{1'b0, 2'd2, 32'h180, 32'h0,        0,  1'b0, 1'b0, 32'h0});
    vt.push_back('{1'b1, 2'd0, 32'h20B, 32'h000000A5, 0,  1'b1, 1'b0, 32'h0});
    vt.push_back('{1'b0, 2'd2, 32'h208, 32'h0,        0,  1'b1, 1'b0, 32'h0});
    vt.push_back('{1'b1, 2'd1, 32'h283, 32'h00001234, 2,  1'b0, 1'b0, 32'h0});
    vt.push_back('{1'b0, 2'd1, 32'h282, 32'h0,        0,  1'b1, 1'b1, 32'h1234});

    rst_n = 1'b0;
    cpu_valid_i = 1'b0; cpu_wen_i = 1'b0; cpu_size_i = 2'b00; cpu_addr_i = '0; cpu_wdata_i = '0;
    mem_lat = 0; exp_addr = '0; exp_wline = '0; stamp = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_cpu_ready", cpu_ready_o, 0);
    chk("rst_mem_valid", mem_valid_o, 0);
    chk("rst_mem_wen", mem_wen_o, 0);
    chk("rst_cpu_rdata", cpu_rdata_o, 0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      do_req(vt[i].wen, vt[i].sz, vt[i].addr, vt[i].wd, vt[i].lat, reads, got);
      chk($sformatf("tbl%0d_hit", i), reads == 0, vt[i].exp_hit);
      if (vt[i].chk_data) chk($sformatf("tbl%0d_data", i), got, vt[i].exp_data);
    end

    // Reset in the middle of a line fill
    exp_addr = 32'h500; mem_lat = 50; rd_cnt = 0;
    cpu_valid_i = 1'b1; cpu_wen_i = 1'b0; cpu_size_i = 2'b10; cpu_addr_i = 32'h500;
    repeat (3) @(negedge clk);
    chk("alloc_valid", mem_valid_o, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_valid", mem_valid_o, 0);
    chk("rst_mid_mem_wen", mem_wen_o, 0);
    chk("rst_mid_cpu_ready", cpu_ready_o, 0);
    chk("rst_mid_cpu_rdata", cpu_rdata_o, 0);
    cpu_valid_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    do_req(1'b0, 2'b10, 32'h500, 32'h0, 0, reads, got);
    chk("rst_remiss", reads, 1);
    do_req(1'b0, 2'b10, 32'h500, 32'h0, 0, reads, got);
    chk("rst_rehit", reads, 0);

    for (int n = 0; n < 200; n++) begin
      w = ($urandom_range(0, 9) < 3);
      z = 2'($urandom_range(0, 3));
      a = (32'($urandom_range(0, 5)) << 7) | (32'($urandom_range(0, 1)) << 4) | 32'($urandom_range(0, 15));
      do_req(w, z, a, $urandom, $urandom_range(0, 3), reads, got);
    end

`ifdef CACHE_STATS_EN
    chk("stat_hits", hit_cnt_o, hits);
    chk("stat_misses", miss_cnt_o, misses);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
